// File: rtl/mips32_pkg.sv
// Shared encodings and pipeline register layouts for the mips32 core.
// An all-zero pipeline register is a NOP bubble.
package mips32_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    alu_op_t     alu_op;
    logic        use_imm;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        beq;
    logic        bne;
    logic        halt;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  dest;
    logic        reg_write;
    logic        halt;
  } mem_wb_t;

endpackage

// File: rtl/mips32_alu.sv
// Combinational integer ALU; zero flag drives branch resolution.
module mips32_alu
  import mips32_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'b0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/mips32_core.sv
// Five-stage in-order MIPS32 subset core with unified word memory,
// full forwarding, load-use stall, EX-stage branch flush and sticky halt.
module mips32_core
  import mips32_pkg::*;
#(
  parameter int         MEM_WORDS  = 1024,
  parameter logic [5:0] HLT_OPCODE = 6'h3F
) (
  input  logic clk1,
  input  logic rst_n,
  output logic halted
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [31:0] Mem [0:MEM_WORDS-1];
  logic [31:0] regs [0:31];
  logic [31:0] PC;
  logic        HALTED;
  logic        TAKEN_BRANCH;
  logic        hlt_seen;

  if_id_t  if_id;
  id_ex_t  id_ex, id_dec;
  ex_mem_t ex_mem, ex_res;
  mem_wb_t mem_wb, mem_res;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt;
  logic        uses_rs, uses_rt, load_use, taken;
  logic [31:0] op_a, op_b, alu_b, alu_result;
  logic        alu_zero;

  assign halted = HALTED;
  assign op     = if_id.instr[31:26];
  assign funct  = if_id.instr[5:0];
  assign rs     = if_id.instr[25:21];
  assign rt     = if_id.instr[20:16];

  // Decode; register reads see a same-cycle WB write.
  always_comb begin
    id_dec       = '0;
    id_dec.pc    = if_id.pc;
    id_dec.rs    = rs;
    id_dec.rt    = rt;
    id_dec.shamt = if_id.instr[10:6];
    id_dec.imm   = {{16{if_id.instr[15]}}, if_id.instr[15:0]};
    id_dec.a     = (mem_wb.reg_write && mem_wb.dest != '0 && mem_wb.dest == rs) ? mem_wb.result : regs[rs];
    id_dec.b     = (mem_wb.reg_write && mem_wb.dest != '0 && mem_wb.dest == rt) ? mem_wb.result : regs[rt];
    uses_rs      = 1'b1;
    uses_rt      = 1'b0;
    case (op)
      OP_RTYPE: begin
        id_dec.dest      = if_id.instr[15:11];
        id_dec.reg_write = 1'b1;
        uses_rt          = 1'b1;
        case (funct)
          FN_ADD:  id_dec.alu_op = ALU_ADD;
          FN_SUB:  id_dec.alu_op = ALU_SUB;
          FN_AND:  id_dec.alu_op = ALU_AND;
          FN_OR:   id_dec.alu_op = ALU_OR;
          FN_SLT:  id_dec.alu_op = ALU_SLT;
          FN_SLL:  id_dec.alu_op = ALU_SLL;
          FN_SRL:  id_dec.alu_op = ALU_SRL;
          default: id_dec.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        id_dec.dest      = rt;
        id_dec.reg_write = 1'b1;
        id_dec.use_imm   = 1'b1;
      end
      OP_LW: begin
        id_dec.dest      = rt;
        id_dec.reg_write = 1'b1;
        id_dec.mem_read  = 1'b1;
        id_dec.use_imm   = 1'b1;
      end
      OP_SW: begin
        id_dec.mem_write = 1'b1;
        id_dec.use_imm   = 1'b1;
        uses_rt          = 1'b1;
      end
      OP_BEQ: begin
        id_dec.beq    = 1'b1;
        id_dec.alu_op = ALU_SUB;
        uses_rt       = 1'b1;
      end
      OP_BNE: begin
        id_dec.bne    = 1'b1;
        id_dec.alu_op = ALU_SUB;
        uses_rt       = 1'b1;
      end
      default: begin
        uses_rs     = 1'b0;
        id_dec.halt = (op == HLT_OPCODE);
      end
    endcase
  end

  assign load_use = id_ex.mem_read && id_ex.dest != '0 &&
                    ((uses_rs && rs == id_ex.dest) || (uses_rt && rt == id_ex.dest));

  // EX operand forwarding: the younger producer (EX/MEM) wins over MEM/WB.
  always_comb begin
    op_a = id_ex.a;
    if (ex_mem.reg_write && !ex_mem.mem_read && ex_mem.dest != '0 && ex_mem.dest == id_ex.rs)
      op_a = ex_mem.result;
    else if (mem_wb.reg_write && mem_wb.dest != '0 && mem_wb.dest == id_ex.rs)
      op_a = mem_wb.result;
    op_b = id_ex.b;
    if (ex_mem.reg_write && !ex_mem.mem_read && ex_mem.dest != '0 && ex_mem.dest == id_ex.rt)
      op_b = ex_mem.result;
    else if (mem_wb.reg_write && mem_wb.dest != '0 && mem_wb.dest == id_ex.rt)
      op_b = mem_wb.result;
  end

  assign alu_b = id_ex.use_imm ? id_ex.imm : op_b;

  mips32_alu u_alu (
    .op     (id_ex.alu_op),
    .a      (op_a),
    .b      (alu_b),
    .shamt  (id_ex.shamt),
    .result (alu_result),
    .zero   (alu_zero)
  );

  assign taken = (id_ex.beq && alu_zero) || (id_ex.bne && !alu_zero);

  always_comb begin
    ex_res            = '0;
    ex_res.result     = alu_result;
    ex_res.store_data = op_b;
    ex_res.dest       = id_ex.dest;
    ex_res.reg_write  = id_ex.reg_write;
    ex_res.mem_read   = id_ex.mem_read;
    ex_res.mem_write  = id_ex.mem_write;
    ex_res.halt       = id_ex.halt;
    mem_res           = '0;
    mem_res.result    = ex_mem.mem_read ? Mem[ex_mem.result[AW-1:0]] : ex_mem.result;
    mem_res.dest      = ex_mem.dest;
    mem_res.reg_write = ex_mem.reg_write;
    mem_res.halt      = ex_mem.halt;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      PC           <= '0;
      HALTED       <= 1'b0;
      TAKEN_BRANCH <= 1'b0;
      hlt_seen     <= 1'b0;
      if_id        <= '0;
      id_ex        <= '0;
      ex_mem       <= '0;
      mem_wb       <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!HALTED) begin
      ex_mem       <= ex_res;
      mem_wb       <= mem_res;
      TAKEN_BRANCH <= taken;
      if (mem_wb.reg_write && mem_wb.dest != '0) regs[mem_wb.dest] <= mem_wb.result;
      if (mem_wb.halt) HALTED <= 1'b1;
      if (taken) begin
        PC    <= id_ex.pc + id_ex.imm;
        if_id <= '0;
        id_ex <= '0;
      end else if (load_use) begin
        id_ex <= '0;
      end else if (hlt_seen || id_dec.halt) begin
        // Once HLT has been decoded, nothing younger is fetched.
        id_ex    <= id_dec;
        if_id    <= '0;
        hlt_seen <= 1'b1;
      end else begin
        id_ex <= id_dec;
        if_id <= '{instr: Mem[PC[AW-1:0]], pc: PC};
        PC    <= PC + 32'd1;
      end
    end
  end

  // Memory has no reset; a reset zeroes EX/MEM so no store is pending.
  always_ff @(posedge clk1) begin
    if (!HALTED && ex_mem.mem_write) Mem[ex_mem.result[AW-1:0]] <= ex_mem.store_data;
  end

endmodule

// File: tb/tb_mips32_core.sv
// Bench for mips32_core: an ISA-level interpreter predicts the ordered
// register/memory updates, final architectural state and taken-branch count.
module tb_mips32_core;

  logic clk1 = 1'b0;
  logic rst_n;
  logic halted;

  mips32_core dut (
    .clk1   (clk1),
    .rst_n  (rst_n),
    .halted (halted)
  );

  always #5 clk1 = ~clk1;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] exp_q[$];   // {reg, value} in program order
  logic [41:0] exp_mq[$];  // {word address, value} in program order
  logic [31:0] init_mem [1024];
  logic [31:0] m_mem [1024];
  logic [31:0] m_regs [32];
  logic [31:0] m_hlt_pc;
  int          m_taken;

  bit          mon_en = 1'b0;
  logic [31:0] prev_regs [32];
  logic [31:0] prev_mem [1024];
  int          taken_seen;
  logic [36:0] e;
  logic [41:0] me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // Sequential interpreter: one instruction at a time, no pipeline notion.
  task automatic run_model();
    logic [31:0] pc, ins, a, b, v, addr, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sh, d;
    bit          wr;
    for (int i = 0; i < 1024; i++) m_mem[i] = init_mem[i];
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    exp_q.delete();
    exp_mq.delete();
    m_taken  = 0;
    m_hlt_pc = '1;
    pc = '0;
    for (int steps = 0; steps < 4000; steps++) begin
      ins = m_mem[pc[9:0]];
      op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
      sh = ins[10:6];  fn = ins[5:0];
      a = m_regs[rs]; b = m_regs[rt];
      nxt = pc + 32'd1; wr = 1'b0; d = '0; v = '0;
      if (op == 6'h3F) begin
        m_hlt_pc = pc;
        break;
      end
      case (op)
        6'h00: begin
          d = rd; wr = 1'b1;
          case (fn)
            6'h20: v = a + b;
            6'h22: v = a - b;
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: v = b << sh;
            6'h02: v = b >> sh;
            default: wr = 1'b0;
          endcase
        end
        6'h08: begin d = rt; wr = 1'b1; v = a + sext(ins[15:0]); end
        6'h23: begin d = rt; wr = 1'b1; addr = a + sext(ins[15:0]); v = m_mem[addr[9:0]]; end
        6'h2B: begin
          addr = a + sext(ins[15:0]);
          if (m_mem[addr[9:0]] !== b) exp_mq.push_back({addr[9:0], b});
          m_mem[addr[9:0]] = b;
        end
        6'h04: if (a == b) begin nxt = pc + sext(ins[15:0]); m_taken++; end
        6'h05: if (a != b) begin nxt = pc + sext(ins[15:0]); m_taken++; end
        default: ;
      endcase
      if (wr && d != '0) begin
        if (m_regs[d] !== v) exp_q.push_back({d, v});
        m_regs[d] = v;
      end
      pc = nxt;
    end
  endtask

  // Per-cycle compare of every visible architectural update against the model order.
  always @(negedge clk1) begin
    if (mon_en) begin
      for (int r = 1; r < 32; r++) begin
        if (dut.regs[r] !== prev_regs[r]) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL reg_commit: got r%0d <= %h, expected no further register update", r, dut.regs[r]);
          end else begin
            e = exp_q.pop_front();
            check("reg_commit_dest", 32'(r), 32'(e[36:32]));
            check("reg_commit_val", dut.regs[r], e[31:0]);
          end
          prev_regs[r] = dut.regs[r];
        end
      end
      for (int m = 64; m < 320; m++) begin
        if (dut.Mem[m] !== prev_mem[m]) begin
          if (exp_mq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL mem_commit: got Mem[%0h] <= %h, expected no further store", m, dut.Mem[m]);
          end else begin
            me = exp_mq.pop_front();
            check("mem_commit_addr", 32'(m), 32'(me[41:32]));
            check("mem_commit_val", dut.Mem[m], me[31:0]);
          end
          prev_mem[m] = dut.Mem[m];
        end
      end
      if (dut.TAKEN_BRANCH) taken_seen++;
    end
  end

  task automatic start_mon();
    for (int r = 0; r < 32; r++) prev_regs[r] = dut.regs[r];
    for (int m = 0; m < 1024; m++) prev_mem[m] = dut.Mem[m];
    taken_seen = 0;
    mon_en = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int budget);
    int cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk1);
      cyc++;
    end
    check({tag, "_halt_reached"}, 32'(halted), 32'd1);
    check({tag, "_pc_at_halt"}, dut.PC, m_hlt_pc + 32'd1);
  endtask

  task automatic final_checks(input string tag);
    check({tag, "_halted_sticky"}, 32'(halted), 32'd1);
    check({tag, "_reg_updates_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_mem_updates_left"}, 32'(exp_mq.size()), 32'd0);
    check({tag, "_taken_count"}, 32'(taken_seen), 32'(m_taken));
    check({tag, "_pc_frozen"}, dut.PC, m_hlt_pc + 32'd1);
    for (int r = 0; r < 32; r++) check($sformatf("%s_r%0d", tag, r), dut.regs[r], m_regs[r]);
    for (int m = 64; m < 320; m++) check($sformatf("%s_mem%0h", tag, m), dut.Mem[m], m_mem[m]);
  endtask

  // Reset, optionally preload memory, release, run to halt and 20 frozen cycles.
  task automatic run_test(input string tag, input int budget, input bit reload);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk1);
    #1;
    if (reload) for (int i = 0; i < 1024; i++) dut.Mem[i] = init_mem[i];
    run_model();
    @(negedge clk1);
    rst_n = 1'b1;
    start_mon();
    wait_halt(tag, budget);
    repeat (20) @(negedge clk1);
    final_checks(tag);
  endtask

  task automatic build_directed();
    logic [31:0] prog [22];
    prog = '{32'h20190200, 32'h20180300, 32'h03191020, 32'h13190002, 32'h17190005,
             32'hAC180050, 32'h20090007, 32'h20090008, 32'h200A0001, 32'h8C100024,
             32'h8C110044, 32'hAC100050, 32'hAC110051, 32'h02119020, 32'h02509822,
             32'h0260A020, 32'h0272A82A, 32'h0015B080, 32'h0016B842, 32'h02F64025,
             32'hFC000000, 32'h20090009};
    for (int i = 0; i < 1024; i++) init_mem[i] = '0;
    for (int i = 0; i < 22; i++) init_mem[i] = prog[i];
    init_mem[8'h24] = 32'd11;
    init_mem[8'h44] = 32'd33;
  endtask

  function automatic logic [31:0] rnd_instr(input int i, input int last);
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm, off;
    logic [31:0] w;
    int          k;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    sh  = 5'($urandom_range(0, 31));
    imm = 16'($urandom);
    off = 16'($urandom_range(1, 4));
    if (int'(off) > last - i) off = 16'(last - i);
    k = $urandom_range(0, 13);
    case (k)
      0:       w = {6'h00, rs, rt, rd, 5'd0, 6'h20};
      1:       w = {6'h00, rs, rt, rd, 5'd0, 6'h22};
      2:       w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3:       w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      4:       w = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      5:       w = {6'h00, 5'd0, rt, rd, sh, 6'h00};
      6:       w = {6'h00, 5'd0, rt, rd, sh, 6'h02};
      7, 8:    w = {6'h08, rs, rt, imm};
      9:       w = {6'h23, 5'd0, rt, 16'h0100 + 16'($urandom_range(0, 31))};
      10:      w = {6'h2B, 5'd0, rt, 16'h0100 + 16'($urandom_range(0, 31))};
      11:      w = {6'h04, rs, rt, off};
      12:      w = {6'h05, rs, rt, off};
      default: w = {6'h0C, rs, rt, imm};
    endcase
    return w;
  endfunction

  task automatic build_random();
    int last = 48;
    for (int i = 0; i < 1024; i++) init_mem[i] = '0;
    for (int i = 0; i < 32; i++) init_mem[256 + i] = $urandom;
    for (int i = 0; i < last; i++) init_mem[i] = rnd_instr(i, last);
    init_mem[last] = {6'h3F, 26'd0};
    for (int i = 1; i <= 4; i++) init_mem[last + i] = {6'h08, 5'd0, 5'($urandom_range(1, 7)), 16'($urandom)};
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pc", dut.PC, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_taken_branch", 32'(dut.TAKEN_BRANCH), 32'd0);
    check("rst_r25", dut.regs[25], 32'd0);

    // Directed program; literals pin the interpreter before it judges the DUT.
    build_directed();
    run_model();
    check("model_r25", m_regs[25], 32'h200);
    check("model_r24", m_regs[24], 32'h300);
    check("model_r2", m_regs[2], 32'h500);
    check("model_s0", m_regs[16], 32'd11);
    check("model_s1", m_regs[17], 32'd33);
    check("model_s2", m_regs[18], 32'd44);
    check("model_s3", m_regs[19], 32'd33);
    check("model_s4", m_regs[20], 32'd33);
    check("model_s5", m_regs[21], 32'd1);
    check("model_s6", m_regs[22], 32'd4);
    check("model_s7", m_regs[23], 32'd2);
    check("model_t0", m_regs[8], 32'd6);
    check("model_t1", m_regs[9], 32'd0);
    check("model_mem50", m_mem[8'h50], 32'd11);
    check("model_mem51", m_mem[8'h51], 32'd33);
    check("model_taken", 32'(m_taken), 32'd1);
    check("model_hlt_pc", m_hlt_pc, 32'd20);

    run_test("dir", 300, 1'b1);
    check("dut_r2", dut.regs[2], 32'h500);
    check("dut_s2", dut.regs[18], 32'd44);
    check("dut_s5", dut.regs[21], 32'd1);
    check("dut_t0", dut.regs[8], 32'd6);
    check("dut_t1_skipped", dut.regs[9], 32'd0);
    check("dut_mem50", dut.Mem[8'h50], 32'd11);
    check("dut_mem51", dut.Mem[8'h51], 32'd33);
    check("dut_pc_after_hlt", dut.PC, 32'd21);

    // Asynchronous reset between edges in the middle of the program.
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk1);
    #1;
    for (int i = 0; i < 1024; i++) dut.Mem[i] = init_mem[i];
    run_model();
    @(negedge clk1);
    rst_n = 1'b1;
    start_mon();
    repeat (8) @(posedge clk1);
    #2;
    check("mid_r25_before_reset", dut.regs[25], 32'h200);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_pc", dut.PC, 32'd0);
    check("mid_rst_halted", 32'(dut.HALTED), 32'd0);
    check("mid_rst_taken_branch", 32'(dut.TAKEN_BRANCH), 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("mid_rst_r%0d", r), dut.regs[r], 32'd0);
    check("mid_rst_mem0_kept", dut.Mem[0], 32'h20190200);
    check("mid_rst_mem24_kept", dut.Mem[8'h24], 32'd11);
    check("mid_rst_mem44_kept", dut.Mem[8'h44], 32'd33);
    run_test("rerun", 300, 1'b0);
    check("rerun_s7", dut.regs[23], 32'd2);
    check("rerun_mem51", dut.Mem[8'h51], 32'd33);

    // Random programs: dense dependencies on r0..r7, forward branches only.
    for (int t = 0; t < 6; t++) begin
      build_random();
      run_test($sformatf("rnd%0d", t), 600, 1'b1);
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
